// File: rtl/latch_q_debounce_sync.sv
// latch_q_debounce_sync: synchronises and debounces the asynchronous latch Q
// output, reports committed level changes as one-cycle pulses, and buffers
// each change as a single-entry valid/ready event.
// Optional feature macro: LATCH_EDGE_COUNT_EN adds a 16-bit wrapping commit
// counter on port edge_count.
module latch_q_debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic q_in,
  output logic q_stable,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic event_valid,
  input  logic event_ready,
  output logic event_type,
  output logic overflow,
  input  logic ovf_clr
`ifdef LATCH_EDGE_COUNT_EN
  ,
  output logic [15:0] edge_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             sync1;
  logic             sync2;
  logic             mismatch;
  logic             commit;
  logic             ovf_set;

  // A committed change needs the level to differ for the full debounce window
  assign mismatch = (sync2 != q_stable);
  assign commit   = mismatch &&
                    (((state == IDLE) && SINGLE) ||
                     ((state == CHECK) && (counter == LAST_CNT)));
  assign ovf_set  = commit && event_valid && !event_ready;

  // Two-flop synchroniser; only sync2 is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= q_in;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: count consecutive mismatch cycles, drop back on a glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (mismatch && !SINGLE) begin
            counter <= CNT_W'(1);
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (!mismatch || (counter == LAST_CNT)) begin
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Committed level and its one-cycle edge pulses, aligned to the commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_stable   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= commit && sync2;
      fall_pulse <= commit && !sync2;
      if (commit) begin
        q_stable <= sync2;
      end
    end
  end

  // Single-entry event buffer; newest commit always wins the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_valid <= 1'b0;
      event_type  <= 1'b0;
    end else if (commit) begin
      event_valid <= 1'b1;
      event_type  <= sync2;
    end else if (event_valid && event_ready) begin
      event_valid <= 1'b0;
    end
  end

  // Sticky overflow on an unconsumed overwrite; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef LATCH_EDGE_COUNT_EN
  // Wrapping count of all commits, rise or fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= 16'h0000;
    end else if (commit) begin
      edge_count <= edge_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_latch_q_debounce_sync.sv
// Bench for latch_q_debounce_sync with DEBOUNCE_CYCLES=4. Expected commits are
// queued with their due cycle when q_in is driven; a negedge monitor pops and
// compares them whenever the DUT emits a pulse.
module tb_latch_q_debounce_sync;

  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = DEB + 2;

  logic clk         = 1'b0;
  logic rst_n       = 1'b0;
  logic q_in        = 1'b0;
  logic event_ready = 1'b0;
  logic ovf_clr     = 1'b0;
  logic q_stable;
  logic rise_pulse;
  logic fall_pulse;
  logic event_valid;
  logic event_type;
  logic overflow;
`ifdef LATCH_EDGE_COUNT_EN
  logic [15:0] edge_count;
  logic [15:0] exp_edges = 16'h0000;
`endif

  typedef struct {
    logic typ;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  latch_q_debounce_sync #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_in       (q_in),
    .q_stable   (q_stable),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_type (event_type),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`ifdef LATCH_EDGE_COUNT_EN
    ,
    .edge_count (edge_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // q_in is driven just after edge cyc; first sampled at cyc+1, commits at cyc+LAT
  task automatic expect_commit(input logic typ);
    sb.push_back('{typ: typ, cyc: cyc + LAT});
  endtask

  // Pulse monitor: every pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (rst_n) begin
      check("pulse_excl", 32'(rise_pulse & fall_pulse), 32'd0);
      if (rise_pulse || fall_pulse) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'({rise_pulse, fall_pulse}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_type", 32'(rise_pulse), 32'(mon_e.typ));
          check("pulse_cycle", cyc, mon_e.cyc);
          check("pulse_level", 32'(q_stable), 32'(mon_e.typ));
`ifdef LATCH_EDGE_COUNT_EN
          exp_edges = exp_edges + 16'h0001;
          check("edge_count", 32'(edge_count), 32'(exp_edges));
`endif
        end
      end
    end
  end

  initial begin
    // Reset with q_in high: everything cleared
    rst_n = 1'b0;
    q_in  = 1'b1;
    tick(2);
    check("rst_q_stable", 32'(q_stable), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_fall", 32'(fall_pulse), 32'd0);
    check("rst_ev_valid", 32'(event_valid), 32'd0);
    check("rst_ev_type", 32'(event_type), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef LATCH_EDGE_COUNT_EN
    check("rst_edge_count", 32'(edge_count), 32'd0);
`endif

    // Release with q_in held high: rise commits LAT edges later
    rst_n = 1'b1;
    expect_commit(1'b1);
    tick(LAT - 1);
    check("t1_not_yet", 32'(q_stable), 32'd0);
    tick(1);
    check("t1_q_stable", 32'(q_stable), 32'd1);
    check("t1_rise", 32'(rise_pulse), 32'd1);
    check("t1_ev_valid", 32'(event_valid), 32'd1);
    check("t1_ev_type", 32'(event_type), 32'd1);
    tick(1);
    check("t1_rise_one_cycle", 32'(rise_pulse), 32'd0);
    event_ready = 1'b1;
    tick(1);
    event_ready = 1'b0;
    check("t1_consumed", 32'(event_valid), 32'd0);

    // 3-cycle glitch is rejected
    q_in = 1'b0;
    tick(3);
    q_in = 1'b1;
    tick(8);
    check("t2_q_stable", 32'(q_stable), 32'd1);
    check("t2_ev_valid", 32'(event_valid), 32'd0);

    // Two unconsumed commits: overwrite sets overflow
    q_in = 1'b0;
    expect_commit(1'b0);
    tick(8);
    check("t3_ev_valid", 32'(event_valid), 32'd1);
    check("t3_ev_type0", 32'(event_type), 32'd0);
    check("t3_ovf0", 32'(overflow), 32'd0);
    q_in = 1'b1;
    expect_commit(1'b1);
    tick(8);
    check("t3_ovf1", 32'(overflow), 32'd1);
    check("t3_ev_type1", 32'(event_type), 32'd1);
    event_ready = 1'b1;
    tick(1);
    event_ready = 1'b0;
    check("t3_consumed", 32'(event_valid), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // Commit on the same cycle the pending event is consumed
    q_in = 1'b0;
    expect_commit(1'b0);
    tick(8);
    q_in = 1'b1;
    expect_commit(1'b1);
    tick(LAT - 1);
    event_ready = 1'b1;
    tick(1);
    event_ready = 1'b0;
    check("t4_ev_valid", 32'(event_valid), 32'd1);
    check("t4_ev_type", 32'(event_type), 32'd1);
    check("t4_ovf", 32'(overflow), 32'd0);

    // Overwrite and ovf_clr on the same edge: set wins
    q_in = 1'b0;
    expect_commit(1'b0);
    tick(LAT - 1);
    ovf_clr = 1'b1;
    tick(1);
    check("t5_set_wins", 32'(overflow), 32'd1);
    check("t5_ev_type", 32'(event_type), 32'd0);
    tick(1);
    ovf_clr = 1'b0;
    check("t5_clr_after", 32'(overflow), 32'd0);
    event_ready = 1'b1;
    tick(1);
    event_ready = 1'b0;
    check("t5_consumed", 32'(event_valid), 32'd0);

    // Reset two cycles into CHECK aborts the pending rise
    q_in = 1'b1;
    tick(4);
    rst_n = 1'b0;
    q_in  = 1'b0;
`ifdef LATCH_EDGE_COUNT_EN
    exp_edges = 16'h0000;
`endif
    tick(2);
    check("t6_rst_q_stable", 32'(q_stable), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("t6_q_stable", 32'(q_stable), 32'd0);
    check("t6_ev_valid", 32'(event_valid), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);

`ifdef LATCH_EDGE_COUNT_EN
    // Preset near the top and commit twice across the wrap
    force dut.edge_count = 16'hFFFE;
    tick(1);
    release dut.edge_count;
    exp_edges = 16'hFFFE;
    q_in = 1'b1;
    expect_commit(1'b1);
    tick(8);
    check("ec_ffff", 32'(edge_count), 32'h0000_FFFF);
    q_in = 1'b0;
    expect_commit(1'b0);
    tick(8);
    check("ec_wrap", 32'(edge_count), 32'd0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
